// File: rtl/vga_game_pkg.sv
// Shared timing constants, game state encoding and colours for the VGA pong renderer.
package vga_game_pkg;

  localparam int unsigned VGA_H_ACT_START = 144;
  localparam int unsigned VGA_V_ACT_START = 35;
  localparam int unsigned VGA_H_ACTIVE    = 640;
  localparam int unsigned VGA_V_ACTIVE    = 480;

  typedef enum logic [1:0] {
    SERVE,
    PLAY,
    MISS
  } game_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t COL_BALL   = 12'hF00;
  localparam rgb12_t COL_PADDLE = 12'hFFF;
  localparam rgb12_t COL_BORDER = 12'h0F0;
  localparam rgb12_t COL_BG     = 12'h000;

endpackage

// File: rtl/vga_frame_tick.sv
// One-cycle pulse on the first cycle y reaches the end of the active area.
module vga_frame_tick
  import vga_game_pkg::*;
#(
  parameter int unsigned V_END = VGA_V_ACT_START + VGA_V_ACTIVE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] y,
  output logic        tick
);

  logic at_end;
  logic at_end_q;

  assign at_end = (y == 16'(V_END));

  always_ff @(posedge clk) begin
    if (rst) at_end_q <= 1'b0;
    else     at_end_q <= at_end;
  end

  assign tick = at_end & ~at_end_q;

endmodule

// File: rtl/vga_pong_renderer.sv
// One-player pong: per-frame game update plus registered 12-bit pixel output.
// Optional 4-pixel green border enabled by defining VGA_RENDER_BORDER_EN.
module vga_pong_renderer
  import vga_game_pkg::*;
#(
  parameter int unsigned H_ACT_START  = VGA_H_ACT_START,
  parameter int unsigned V_ACT_START  = VGA_V_ACT_START,
  parameter int unsigned H_ACTIVE     = VGA_H_ACTIVE,
  parameter int unsigned V_ACTIVE     = VGA_V_ACTIVE,
  parameter int unsigned PAD_X        = 16,
  parameter int unsigned PAD_W        = 8,
  parameter int unsigned PAD_H        = 64,
  parameter int unsigned BALL         = 8,
  parameter int unsigned PAD_SPEED    = 4,
  parameter int unsigned BALL_SPEED   = 2,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        Hsynq,
  input  logic        Vsynq,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        Hsynq_o,
  output logic        Vsynq_o,
  output logic [7:0]  hits,
  output logic [7:0]  misses
);

  localparam logic [10:0] PAD_L   = 11'(PAD_X);
  localparam logic [10:0] PAD_R   = 11'(PAD_X + PAD_W);
  localparam logic [10:0] PH      = 11'(PAD_H);
  localparam logic [10:0] BSZ     = 11'(BALL);
  localparam logic [10:0] BSPD    = 11'(BALL_SPEED);
  localparam logic [10:0] PSPD    = 11'(PAD_SPEED);
  localparam logic [10:0] BX_MAX  = 11'(H_ACTIVE - BALL);
  localparam logic [10:0] BY_MAX  = 11'(V_ACTIVE - BALL);
  localparam logic [10:0] PAD_MAX = 11'(V_ACTIVE - PAD_H);
  localparam logic [10:0] CX      = 11'((H_ACTIVE - BALL) / 2);
  localparam logic [10:0] CY      = 11'((V_ACTIVE - BALL) / 2);
  localparam logic [10:0] PAD_RST = 11'((V_ACTIVE - PAD_H) / 2);
  localparam logic [7:0]  SF      = 8'(SERVE_FRAMES);

  logic tick;

  vga_frame_tick #(.V_END(V_ACT_START + V_ACTIVE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .y    (y),
    .tick (tick)
  );

  game_state_t state, n_state;
  logic [10:0] pad_y, n_pad, bx, n_bx, by, n_by;
  logic        dx, n_dx, dy, n_dy;
  logic [7:0]  serve_cnt, n_cnt, n_hits, n_misses;
  logic        hit, lost;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SERVE;
      serve_cnt <= '0;
      pad_y     <= PAD_RST;
      bx        <= CX;
      by        <= CY;
      dx        <= 1'b1;
      dy        <= 1'b1;
      hits      <= '0;
      misses    <= '0;
    end else begin
      state     <= n_state;
      serve_cnt <= n_cnt;
      pad_y     <= n_pad;
      bx        <= n_bx;
      by        <= n_by;
      dx        <= n_dx;
      dy        <= n_dy;
      hits      <= n_hits;
      misses    <= n_misses;
    end
  end

  always_comb begin
    n_state  = state;
    n_cnt    = serve_cnt;
    n_pad    = pad_y;
    n_bx     = bx;
    n_by     = by;
    n_dx     = dx;
    n_dy     = dy;
    n_hits   = hits;
    n_misses = misses;
    hit      = 1'b0;
    lost     = 1'b0;
    if (tick) begin
      if (btn_up && !btn_down)
        n_pad = (pad_y < PSPD) ? '0 : pad_y - PSPD;
      else if (btn_down && !btn_up)
        n_pad = (pad_y + PSPD > PAD_MAX) ? PAD_MAX : pad_y + PSPD;

      unique case (state)
        SERVE: begin
          n_bx = CX;
          n_by = CY;
          n_dx = 1'b1;
          if (serve_cnt + 8'd1 == SF) begin
            n_state = PLAY;
            n_cnt   = '0;
          end else begin
            n_cnt = serve_cnt + 8'd1;
          end
        end
        PLAY: begin
          // Hit test uses the paddle position from before this tick's move.
          hit  = !dx && bx >= PAD_R && bx - BSPD <= PAD_R &&
                 by + BSZ > pad_y && by < pad_y + PH;
          lost = !hit && !dx && bx < BSPD;
          if (hit) begin
            n_bx   = PAD_R;
            n_dx   = 1'b1;
            n_hits = hits + 8'd1;
          end else if (lost) begin
            n_state  = MISS;
            n_misses = misses + 8'd1;
          end else if (dx && bx + BSPD >= BX_MAX) begin
            n_bx = BX_MAX;
            n_dx = 1'b0;
          end else begin
            n_bx = dx ? bx + BSPD : bx - BSPD;
          end
          if (!lost) begin
            if (!dy && by < BSPD) begin
              n_by = '0;
              n_dy = 1'b1;
            end else if (dy && by + BSPD >= BY_MAX) begin
              n_by = BY_MAX;
              n_dy = 1'b0;
            end else begin
              n_by = dy ? by + BSPD : by - BSPD;
            end
          end
        end
        MISS: begin
          n_state = SERVE;
          n_bx    = CX;
          n_by    = CY;
          n_dx    = 1'b1;
        end
        default: n_state = SERVE;
      endcase
    end
  end

  logic        active, on_ball, on_pad, on_border;
  logic [9:0]  px, py;
  logic [10:0] px11, py11;
  rgb12_t      pix;

  assign active = (x >= 16'(H_ACT_START)) && (x < 16'(H_ACT_START + H_ACTIVE)) &&
                  (y >= 16'(V_ACT_START)) && (y < 16'(V_ACT_START + V_ACTIVE));
  assign px   = 10'(x - 16'(H_ACT_START));
  assign py   = 10'(y - 16'(V_ACT_START));
  assign px11 = {1'b0, px};
  assign py11 = {1'b0, py};

  assign on_ball = px11 >= bx && px11 < bx + BSZ && py11 >= by && py11 < by + BSZ;
  assign on_pad  = px11 >= PAD_L && px11 < PAD_R && py11 >= pad_y && py11 < pad_y + PH;
`ifdef VGA_RENDER_BORDER_EN
  assign on_border = px < 10'd4 || px >= 10'(H_ACTIVE - 4) ||
                     py < 10'd4 || py >= 10'(V_ACTIVE - 4);
`else
  assign on_border = 1'b0;
`endif

  always_comb begin
    pix = COL_BG;
    if (!active)        pix = '0;
    else if (on_ball)   pix = COL_BALL;
    else if (on_pad)    pix = COL_PADDLE;
    else if (on_border) pix = COL_BORDER;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red     <= '0;
      green   <= '0;
      blue    <= '0;
      Hsynq_o <= 1'b0;
      Vsynq_o <= 1'b0;
    end else begin
      red     <= pix.r;
      green   <= pix.g;
      blue    <= pix.b;
      Hsynq_o <= Hsynq;
      Vsynq_o <= Vsynq;
    end
  end

endmodule

// File: tb/tb_vga_pong_renderer.sv
// Directed + randomized bench for vga_pong_renderer with an integer game model.
module tb_vga_pong_renderer;
  import vga_game_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] x, y;
  logic        Hsynq, Vsynq, btn_up, btn_down;
  logic [3:0]  red, green, blue;
  logic        Hsynq_o, Vsynq_o;
  logic [7:0]  hits, misses;

  vga_pong_renderer dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .Hsynq(Hsynq), .Vsynq(Vsynq),
    .btn_up(btn_up), .btn_down(btn_down), .red(red), .green(green), .blue(blue),
    .Hsynq_o(Hsynq_o), .Vsynq_o(Vsynq_o), .hits(hits), .misses(misses)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          m_pad, m_bx, m_by, m_cnt, m_hits, m_miss;
  bit          m_dx, m_dy;
  game_state_t m_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pad = 208; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
    m_st = SERVE; m_cnt = 0; m_hits = 0; m_miss = 0;
  endtask

  task automatic model_tick(input bit up, input bit dn);
    int old_pad;
    old_pad = m_pad;
    if (up && !dn)      m_pad = (m_pad < 4) ? 0 : m_pad - 4;
    else if (dn && !up) m_pad = (m_pad + 4 > 416) ? 416 : m_pad + 4;
    case (m_st)
      SERVE: begin
        m_bx = 316; m_by = 236; m_dx = 1;
        m_cnt++;
        if (m_cnt == 60) begin m_st = PLAY; m_cnt = 0; end
      end
      PLAY: begin
        if (!m_dx && m_bx >= 24 && m_bx - 2 <= 24 && m_by + 8 > old_pad && m_by < old_pad + 64) begin
          m_bx = 24; m_dx = 1; m_hits = (m_hits + 1) % 256;
        end else if (!m_dx && m_bx < 2) begin
          m_st = MISS; m_miss = (m_miss + 1) % 256;
        end else if (m_dx && m_bx + 2 >= 632) begin
          m_bx = 632; m_dx = 0;
        end else begin
          m_bx = m_dx ? m_bx + 2 : m_bx - 2;
        end
        if (m_st == PLAY) begin
          if (!m_dy && m_by < 2)              begin m_by = 0;   m_dy = 1; end
          else if (m_dy && m_by + 2 >= 472)   begin m_by = 472; m_dy = 0; end
          else m_by = m_dy ? m_by + 2 : m_by - 2;
        end
      end
      default: begin
        m_st = SERVE; m_bx = 316; m_by = 236; m_dx = 1;
      end
    endcase
  endtask

  function automatic logic [11:0] exp_pix(input int xx, input int yy);
    int px, py;
    if (xx < 144 || xx >= 784 || yy < 35 || yy >= 515) return 12'h000;
    px = xx - 144;
    py = yy - 35;
    if (px >= m_bx && px < m_bx + 8 && py >= m_by && py < m_by + 8) return 12'hF00;
    if (px >= 16 && px < 24 && py >= m_pad && py < m_pad + 64) return 12'hFFF;
`ifdef VGA_RENDER_BORDER_EN
    if (px < 4 || px >= 636 || py < 4 || py >= 476) return 12'h0F0;
`endif
    return 12'h000;
  endfunction

  task automatic check_state();
    chk("pad_y", dut.pad_y, m_pad);
    chk("bx", dut.bx, m_bx);
    chk("by", dut.by, m_by);
    chk("dx", dut.dx, m_dx);
    chk("dy", dut.dy, m_dy);
    chk("state", dut.state, m_st);
    chk("serve_cnt", dut.serve_cnt, m_cnt);
    chk("hits", hits, m_hits);
    chk("misses", misses, m_miss);
  endtask

  task automatic frame(input bit up, input bit dn);
    btn_up = up; btn_down = dn;
    x = 16'd0; y = 16'd515;
    step();
    step();
    y = 16'd0;
    step();
    model_tick(up, dn);
    check_state();
  endtask

  task automatic pixel(input int xx, input int yy, input bit hs, input bit vs, input string tag);
    x = 16'(xx); y = 16'(yy); Hsynq = hs; Vsynq = vs;
    step();
    chk(tag, {red, green, blue}, exp_pix(xx, yy));
    chk("hsync_o", Hsynq_o, hs);
    chk("vsync_o", Vsynq_o, vs);
  endtask

  task automatic random_pixel();
    int xx, yy;
    if ($urandom_range(0, 1) == 1) begin
      xx = 144 + m_bx + $urandom_range(0, 11) - 2;
      yy = 35 + m_by + $urandom_range(0, 11) - 2;
    end else begin
      xx = $urandom_range(0, 799);
      yy = $urandom_range(0, 523);
    end
    if (yy == 515) yy = 516;
    pixel(xx, yy, 1'($urandom), 1'($urandom), "rgb_rand");
  endtask

  initial begin
    bit up, dn;
    rst = 1'b1; x = '0; y = '0; Hsynq = 1'b0; Vsynq = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    model_reset();
    step();
    step();
    chk("rgb_reset", {red, green, blue}, 12'h000);
    chk("hsync_reset", Hsynq_o, 1'b0);
    rst = 1'b0;
    step();
    check_state();

    // Pipeline alignment and static scene
    pixel(144 + 316, 35 + 236, 1'b1, 1'b0, "rgb_ball");
    pixel(144 + 320, 35 + 240, 1'b0, 1'b1, "rgb_ball_mid");
    pixel(144 + 18, 35 + 210, 1'b1, 1'b1, "rgb_paddle");
    pixel(144 + 1, 35 + 100, 1'b0, 1'b0, "rgb_edge");
    pixel(144 + 300, 35 + 100, 1'b1, 1'b0, "rgb_bg");
    pixel(100, 35 + 236, 1'b0, 1'b1, "rgb_blank");

    // Serve period with the paddle driven hard into the top clamp
    for (int i = 0; i < 60; i++) frame(1'b1, 1'b0);
    chk("pad_clamped", dut.pad_y, 0);
    chk("state_play", dut.state, PLAY);
    frame(1'b1, 1'b1);
    chk("serve_move_bx", dut.bx, 318);

    // Random play: mostly tracking paddle first, then an avoiding paddle
    for (int i = 0; i < 2600; i++) begin
      int pc, bc;
      pc = m_pad + 32;
      bc = m_by + 4;
      if (i < 1500 ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 15)) begin
        up = (pc > bc + 2); dn = (pc < bc - 2);
      end else if (i >= 1500) begin
        up = (bc > 240); dn = (bc <= 240);
      end else begin
        up = 1'($urandom); dn = 1'($urandom);
      end
      random_pixel();
      frame(up, dn);
    end

    // Reset during active video
    x = 16'(144 + 50); y = 16'(35 + 50); rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    chk("rgb_mid_reset", {red, green, blue}, 12'h000);
    y = 16'd0;
    step();
    check_state();

    // A tick coinciding with reset is dropped
    frame(1'b0, 1'b1);
    y = 16'd515; rst = 1'b1;
    step();
    rst = 1'b0; y = 16'd0;
    step();
    model_reset();
    check_state();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
